eq_ram_ctrl: RTL and testbench
==============================

# eq_ram_ctrl

Sequencer and arbiter for the EQ coefficient/sample RAM (single-port, synchronous write, asynchronous read). It shares the RAM between a configuration write requester and the filter MAC's tap reader. On a start request it sweeps addresses 0..len-1 and streams registered taps to the MAC under valid/ready flow control. Host writes are granted only between sweeps. It sits between the host config interface, the RAM and the MAC datapath.

## Interface
- RAM_HEIGHT, 279, number of RAM words; the maximum sweep length.
- RAM_WIDTH, 16, data width and RAM address-port width.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_req  in  1  write request; held high until cfg_ack.
- cfg_addr  in  RAM_WIDTH  write address.
- cfg_data  in  RAM_WIDTH  write data, signed.
- cfg_ack  out  1  one-cycle pulse; request consumed.
- cfg_err  out  1  pulses with cfg_ack when cfg_addr >= RAM_HEIGHT; no write occurs.
- start  in  1  one-cycle pulse; requests one sweep.
- sweep_len  in  RAM_WIDTH  tap count, sampled when the sweep begins.
- busy  out  1  high in the WRITE and SWEEP states.
- start_ovf  out  1  one-cycle pulse when a start is dropped.
- tap_valid  out  1  tap output valid.
- tap_ready  in  1  MAC accepts the tap.
- tap_data  out  RAM_WIDTH  registered RAM read data, signed.
- tap_idx  out  RAM_WIDTH  address of tap_data.
- tap_last  out  1  marks the final tap of a sweep.
- ram_we, ram_a, ram_di  out  1/RAM_WIDTH/RAM_WIDTH  RAM control.
- ram_do  in  RAM_WIDTH  asynchronous RAM read data.

## Operation
- States:
  - IDLE: no activity.
  - WRITE: exactly one cycle.
  - SWEEP: reads taps. cnt is the read address and len_q is the latched length.
- IDLE transitions, checked in priority order:
  - cfg_req → WRITE. addr/data are captured; err = (cfg_addr >= RAM_HEIGHT).
  - Else start or pending → SWEEP. cnt = 0; len_q = clamp(sweep_len); pending is cleared.
- clamp: a length of 0 or a length > RAM_HEIGHT becomes RAM_HEIGHT.
- WRITE:
  - ram_we = !err, ram_a = addr_q, ram_di = data_q.
  - cfg_ack = 1; cfg_err = err.
  - Next state is SWEEP if pending, else IDLE.
- SWEEP: ram_a = cnt and ram_we = 0. At each advance edge (advance = !tap_valid || tap_ready):
  - tap_data ← ram_do, tap_idx ← cnt, tap_valid ← 1, tap_last ← (cnt == len_q-1).
  - Then cnt increments.
  - After loading cnt = len_q-1 the block returns to IDLE. The last tap is still presented there.
- Tap output register:
  - It holds while tap_valid && !tap_ready.
  - tap_valid clears on an edge with tap_ready and no new load.
- ram_a and ram_di are 0 when neither WRITE nor SWEEP drives them. ram_we is 0 outside WRITE.
- start while not idle, or coincident with an IDLE cfg_req:
  - pending is set if clear.
  - If pending is already set, the start is dropped and start_ovf pulses. The pending depth is one.
- cfg_req during SWEEP is not acknowledged; the requester holds. A cfg write never interleaves with a sweep.
- Reset, asynchronous, including mid-sweep or mid-write:
  - State returns to IDLE; cnt, len_q and pending clear.
  - All outputs go to 0: cfg_ack, cfg_err, busy, start_ovf, tap_*, ram_we, ram_a, ram_di.
  - An interrupted sweep is abandoned, not resumed.

## Timing
- Write: cfg_req sampled at edge E0 → WRITE during the E0–E1 cycle → RAM updated and cfg_ack seen at E1. Requester drops cfg_req after the ack.
- Sweep with tap_ready held high: start at E0 → taps valid after E1..E_len (len consecutive cycles) → tap_last with tap_idx = len-1 after E_len.
- Back-to-back: a pending sweep starts at the edge after WRITE or after the final load. No idle bubble is required between consecutive sweeps.
- Backpressure adds exactly one cycle per stalled cycle. cnt never runs ahead of the output register.

## Structure
- Shared eq package: state enum (IDLE, WRITE, SWEEP) and the default RAM_HEIGHT and RAM_WIDTH constants.
- Single module. No sub-module: the RAM is instantiated alongside this block, not inside it.

## Test plan
- Write 0x1234 to address 5, then a sweep of len 8:
  - cfg_ack pulses once.
  - The tap at idx 5 reads 0x1234; idx 0..7 arrive in order, with tap_last on idx 7.
- cfg_addr = 279: cfg_ack and cfg_err pulse together, ram_we stays 0, and the RAM contents are unchanged.
- Sweep of len 4 with tap_ready low for 3 cycles at idx 2: tap_data/idx hold at 2, then the sweep completes with 3 extra cycles.
- Starts at +0 and +1 during a sweep, then a third start:
  - The first start is pending and runs immediately after.
  - The third start causes a start_ovf pulse and is dropped.
- cfg_req and start together in IDLE: the write occurs first, then the sweep begins at the next edge. sweep_len = 0 yields 279 taps.
- rst_n asserted mid-sweep at idx 10: all outputs are 0 immediately. After release the block is idle, and a new start restarts from idx 0.

Source files
------------

// File: rtl/eq_ram_ctrl_pkg.sv
// eq_ram_ctrl_pkg: shared types and default sizes for the EQ coefficient/sample
// RAM controller.
//   EQ_RAM_HEIGHT : default number of RAM words (maximum sweep length)
//   EQ_RAM_WIDTH  : default data / address-port width
//   state_e       : controller state encoding
package eq_ram_ctrl_pkg;

  localparam int EQ_RAM_HEIGHT = 279;
  localparam int EQ_RAM_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    SWEEP = 2'd2
  } state_e;

endpackage

// File: rtl/eq_ram_ctrl.sv
// eq_ram_ctrl: arbitrates the single-port EQ RAM between host config writes and
// the MAC tap reader. A start sweeps addresses 0..len-1 and streams registered
// taps under valid/ready. Host writes are only granted between sweeps.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cfg_req/addr/data, cfg_ack/err  host write request / one-cycle response
//   start, sweep_len, start_ovf     sweep request, length, dropped-start pulse
//   busy                            high in WRITE and SWEEP
//   tap_valid/ready/data/idx/last   tap stream to the MAC
//   ram_we/a/di, ram_do             RAM control, async read data
module eq_ram_ctrl
  import eq_ram_ctrl_pkg::*;
#(
  parameter int RAM_HEIGHT = EQ_RAM_HEIGHT,
  parameter int RAM_WIDTH  = EQ_RAM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_req,
  input  logic [RAM_WIDTH-1:0] cfg_addr,
  input  logic [RAM_WIDTH-1:0] cfg_data,
  output logic                 cfg_ack,
  output logic                 cfg_err,
  input  logic                 start,
  input  logic [RAM_WIDTH-1:0] sweep_len,
  output logic                 busy,
  output logic                 start_ovf,
  output logic                 tap_valid,
  input  logic                 tap_ready,
  output logic [RAM_WIDTH-1:0] tap_data,
  output logic [RAM_WIDTH-1:0] tap_idx,
  output logic                 tap_last,
  output logic                 ram_we,
  output logic [RAM_WIDTH-1:0] ram_a,
  output logic [RAM_WIDTH-1:0] ram_di,
  input  logic [RAM_WIDTH-1:0] ram_do
);

  localparam logic [RAM_WIDTH-1:0] HEIGHT_W = RAM_WIDTH'(RAM_HEIGHT);
  localparam logic [RAM_WIDTH-1:0] ONE_W    = RAM_WIDTH'(1);

  state_e               state_q;
  logic [RAM_WIDTH-1:0] cnt_q, len_q, addr_q, data_q;
  logic                 err_q, pending_q, start_ovf_q;
  logic                 tap_valid_q, tap_last_q;
  logic [RAM_WIDTH-1:0] tap_data_q, tap_idx_q;

  logic                 idle_free, idle_go_sweep, start_defer, pend_take;
  logic                 sweep_adv, sweep_done, pending_d;
  logic [RAM_WIDTH-1:0] len_d;

  always_comb begin
    // IDLE only launches a sweep when no write competes for the RAM.
    idle_free     = (state_q == IDLE) && !cfg_req;
    idle_go_sweep = idle_free && (start || pending_q);
    // Any start that cannot launch a sweep right now is queued (depth one).
    start_defer   = start && !idle_free;
    pend_take     = idle_go_sweep || ((state_q == WRITE) && pending_q);
    pending_d     = (pending_q && !pend_take) || (start_defer && !pending_q);
    // Reads only advance when the output register is empty or being drained,
    // so cnt never runs ahead of the tap presented to the MAC.
    sweep_adv     = (state_q == SWEEP) && (!tap_valid_q || tap_ready);
    sweep_done    = sweep_adv && (cnt_q == len_q - ONE_W);
    len_d         = (sweep_len == '0 || sweep_len > HEIGHT_W) ? HEIGHT_W : sweep_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      pending_q   <= 1'b0;
      start_ovf_q <= 1'b0;
      tap_valid_q <= 1'b0;
      tap_last_q  <= 1'b0;
      tap_data_q  <= '0;
      tap_idx_q   <= '0;
    end else begin
      pending_q   <= pending_d;
      start_ovf_q <= start_defer && pending_q;

      case (state_q)
        IDLE: begin
          if (cfg_req) begin
            state_q <= WRITE;
            addr_q  <= cfg_addr;
            data_q  <= cfg_data;
            err_q   <= (cfg_addr >= HEIGHT_W);
          end else if (idle_go_sweep) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            len_q   <= len_d;
          end
        end
        WRITE: begin
          if (pending_q) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            len_q   <= len_d;
          end else begin
            state_q <= IDLE;
          end
        end
        SWEEP: begin
          if (sweep_adv) begin
            cnt_q <= cnt_q + ONE_W;
            if (sweep_done) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Tap output register: load on advance, drain on ready, else hold.
      if (sweep_adv) begin
        tap_valid_q <= 1'b1;
        tap_data_q  <= ram_do;
        tap_idx_q   <= cnt_q;
        tap_last_q  <= (cnt_q == len_q - ONE_W);
      end else if (tap_ready) begin
        tap_valid_q <= 1'b0;
      end
    end
  end

  assign cfg_ack   = (state_q == WRITE);
  assign cfg_err   = (state_q == WRITE) && err_q;
  assign busy      = (state_q != IDLE);
  assign start_ovf = start_ovf_q;
  assign tap_valid = tap_valid_q;
  assign tap_data  = tap_data_q;
  assign tap_idx   = tap_idx_q;
  assign tap_last  = tap_last_q;
  assign ram_we    = (state_q == WRITE) && !err_q;
  assign ram_a     = (state_q == WRITE) ? addr_q :
                     (state_q == SWEEP) ? cnt_q  : '0;
  assign ram_di    = (state_q == WRITE) ? data_q : '0;

endmodule

// File: tb/tb_eq_ram_ctrl.sv
// tb_eq_ram_ctrl: self-checking bench for eq_ram_ctrl with a behavioural RAM.
// Expected taps are queued when a sweep is requested and compared as the MAC
// side accepts them.
module tb_eq_ram_ctrl;

  localparam int          H  = 279;
  localparam logic [15:0] HW = 16'd279;

  logic        clk, rst_n;
  logic        cfg_req, cfg_ack, cfg_err;
  logic [15:0] cfg_addr, cfg_data;
  logic        start, busy, start_ovf;
  logic [15:0] sweep_len;
  logic        tap_valid, tap_ready, tap_last;
  logic [15:0] tap_data, tap_idx;
  logic        ram_we;
  logic [15:0] ram_a, ram_di, ram_do;

  eq_ram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .start(start), .sweep_len(sweep_len), .busy(busy), .start_ovf(start_ovf),
    .tap_valid(tap_valid), .tap_ready(tap_ready), .tap_data(tap_data),
    .tap_idx(tap_idx), .tap_last(tap_last),
    .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, asynchronous read.
  logic [15:0] mem    [H];
  logic [15:0] shadow [H];
  always @(posedge clk) if (ram_we && ram_a < HW) mem[ram_a] <= ram_di;
  assign ram_do = (ram_a < HW) ? mem[ram_a] : 16'h0;

  typedef struct packed {
    logic [15:0] idx;
    logic [15:0] data;
    logic        last;
  } tap_t;

  tap_t exp_q[$];
  int   n_chk = 0, n_fail = 0, n_we = 0, n_ovf = 0;

  // Scoreboard: every accepted tap must match the head of the queue.
  always @(negedge clk) begin
    tap_t e;
    if (rst_n) begin
      if (ram_we) n_we++;
      if (start_ovf) n_ovf++;
      if (tap_valid && tap_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL tap_unexpected: got idx %0d data %h, required no tap", tap_idx, tap_data);
        end else begin
          e = exp_q.pop_front();
          if ({tap_idx, tap_data, tap_last} !== {e.idx, e.data, e.last}) begin
            n_fail++;
            $display("FAIL tap: got idx %0d data %h last %b, required idx %0d data %h last %b",
                     tap_idx, tap_data, tap_last, e.idx, e.data, e.last);
          end
        end
      end
    end
  end

  task automatic push_sweep(input int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back('{idx: 16'(i), data: shadow[i], last: (i == len - 1)});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d taps outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic exp_err);
    logic seen = 1'b0;
    @(posedge clk); #1;
    cfg_req = 1'b1; cfg_addr = a; cfg_data = d;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (cfg_ack) begin
        seen = 1'b1;
        cfg_req = 1'b0;
        n_chk++;
        if ({cfg_err, ram_we} !== {exp_err, !exp_err}) begin
          n_fail++;
          $display("FAIL write_ack: got err %b we %b, required err %b we %b",
                   cfg_err, ram_we, exp_err, !exp_err);
        end
      end
    end
    cfg_req = 1'b0;
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL write_timeout: got no cfg_ack, required cfg_ack within 20 cycles");
    end
    @(posedge clk); #1;
    n_chk++;
    if (cfg_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_pulse: got cfg_ack %b one cycle later, required 0", cfg_ack);
    end
    if (seen && !exp_err) shadow[a] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({cfg_ack, cfg_err, busy, start_ovf, tap_valid, tap_last, ram_we,
         tap_data, tap_idx, ram_a, ram_di} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy %b tap_valid %b ram_a %h, required all 0",
               busy, tap_valid, ram_a);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({busy, tap_valid, cfg_ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: got busy %b tap_valid %b ack %b, required 000", busy, tap_valid, cfg_ack);
    end
  endtask

  task automatic test_write_sweep();
    int  n = 0;
    logic seen = 1'b0;
    do_write(16'd5, 16'h1234, 1'b0);
    n_chk++;
    if (shadow[5] !== 16'h1234 || mem[5] !== 16'h1234) begin
      n_fail++;
      $display("FAIL write_data: got mem[5] %h, required 1234", mem[5]);
    end
    @(posedge clk); #1;
    start = 1'b1; sweep_len = 16'd8;
    push_sweep(8);
    while (n < 40 && !seen) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (tap_valid && tap_last) seen = 1'b1;
    end
    n_chk++;
    if (!seen || n != 9 || tap_idx !== 16'd7) begin
      n_fail++;
      $display("FAIL sweep_latency: got last after %0d edges idx %0d, required 9 edges idx 7", n, tap_idx);
    end
    drain(40);
  endtask

  task automatic test_err_write();
    int we0 = n_we;
    do_write(HW, 16'hDEAD, 1'b1);
    n_chk++;
    if (n_we != we0) begin
      n_fail++;
      $display("FAIL err_no_write: got %0d ram_we cycles, required 0", n_we - we0);
    end
  endtask

  task automatic test_backpressure();
    int  n = 0, stalled = 0;
    logic seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; sweep_len = 16'd4;
    push_sweep(4);
    while (n < 50 && !seen) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (tap_valid && tap_idx == 16'd2 && stalled < 3) begin
        if (stalled > 0) begin
          n_chk++;
          if (tap_data !== shadow[2]) begin
            n_fail++;
            $display("FAIL stall_hold: got data %h, required %h", tap_data, shadow[2]);
          end
        end
        tap_ready = 1'b0;
        stalled++;
      end else begin
        tap_ready = 1'b1;
      end
      if (tap_valid && tap_last && tap_ready) seen = 1'b1;
    end
    tap_ready = 1'b1;
    n_chk++;
    if (!seen || n != 8) begin
      n_fail++;
      $display("FAIL stall_latency: got last after %0d edges, required 8", n);
    end
    drain(40);
  endtask

  task automatic test_pending();
    int ovf0 = n_ovf;
    @(posedge clk); #1;
    start = 1'b1; sweep_len = 16'd5;
    push_sweep(5);
    push_sweep(5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    drain(100);
    n_chk++;
    if (n_ovf - ovf0 != 1) begin
      n_fail++;
      $display("FAIL start_ovf: got %0d pulses, required 1", n_ovf - ovf0);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_idle: got busy %b, required 0", busy);
    end
  endtask

  task automatic test_cfg_and_start();
    @(posedge clk); #1;
    cfg_req = 1'b1; cfg_addr = 16'd20; cfg_data = 16'hBEEF;
    start = 1'b1; sweep_len = 16'd0;
    shadow[20] = 16'hBEEF;
    push_sweep(H);
    @(posedge clk); #1;
    start = 1'b0;
    n_chk++;
    if ({cfg_ack, cfg_err, ram_we} !== 3'b101) begin
      n_fail++;
      $display("FAIL cfg_first: got ack %b err %b we %b, required 1 0 1", cfg_ack, cfg_err, ram_we);
    end
    cfg_req = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if ({busy, cfg_ack, tap_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL sweep_after_write: got busy %b ack %b valid %b, required 1 0 0", busy, cfg_ack, tap_valid);
    end
    @(posedge clk); #1;
    n_chk++;
    if (tap_valid !== 1'b1 || tap_idx !== 16'd0) begin
      n_fail++;
      $display("FAIL first_tap: got valid %b idx %0d, required 1 idx 0", tap_valid, tap_idx);
    end
    drain(400);
  endtask

  task automatic test_reset_mid_sweep();
    int   n = 0;
    logic seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; sweep_len = 16'd30;
    push_sweep(30);
    while (n < 40 && !seen) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (tap_valid && tap_idx == 16'd10) seen = 1'b1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL reach_idx10: got idx %0d, required idx 10 within 40 cycles", tap_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({cfg_ack, cfg_err, busy, start_ovf, tap_valid, tap_last, ram_we,
         tap_data, tap_idx, ram_a, ram_di} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy %b valid %b idx %0d ram_a %h, required all 0",
               busy, tap_valid, tap_idx, ram_a);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({busy, tap_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy %b valid %b, required 00", busy, tap_valid);
    end
    start = 1'b1; sweep_len = 16'd3;
    push_sweep(3);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (tap_valid !== 1'b1 || tap_idx !== 16'd0) begin
      n_fail++;
      $display("FAIL restart_idx0: got valid %b idx %0d, required 1 idx 0", tap_valid, tap_idx);
    end
    drain(20);
  endtask

  initial begin
    for (int i = 0; i < H; i++) begin
      mem[i]    = 16'(i * 7 + 16'h0100);
      shadow[i] = 16'(i * 7 + 16'h0100);
    end
    cfg_req = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; sweep_len = '0; tap_ready = 1'b1;
    test_reset();
    test_write_sweep();
    test_err_write();
    test_backpressure();
    test_pending();
    test_cfg_and_start();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
